cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Common Data Bus arbiter and broadcaster. It is the consuming end of the functional-unit result interface: every execution unit (multiplier, ALU, load unit, ...) presents a valid/ready result carrying a tag and data. One result per cycle wins round-robin arbitration and is registered onto the CDB, which reservation stations, the register file and the ROB snoop.

Parameters:
- N_PORT, 4, number of functional-unit result ports; must be at least 2.
- BW_PROCESSOR_DATA, 32, result data width.
- BW_TAG, 4, producer tag width.
- BW_PORT, $clog2(N_PORT), width of the source-index output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- i_fu_valid  input  N_PORT  per-port result valid.
- i_fu_ready  output  N_PORT  per-port accept; one-hot or zero.
- i_fu_tag_flatten  input  N_PORT*BW_TAG  port p tag at [p*BW_TAG +: BW_TAG].
- i_fu_wdata_flatten  input  N_PORT*BW_PROCESSOR_DATA  port p data at [p*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA].
- o_cdb_valid  output  1  broadcast valid; no back-pressure.
- o_cdb_tag  output  BW_TAG  broadcast tag.
- o_cdb_wdata  output  BW_PROCESSOR_DATA  broadcast data.
- o_cdb_src  output  BW_PORT  index of the port that produced the current broadcast.

Behaviour:
- Reset (rst=1 at the clock edge): o_cdb_valid=0, o_cdb_tag=0, o_cdb_wdata=0, o_cdb_src=0, round-robin pointer rr_ptr=0.
  - While rst=1, i_fu_ready is forced to 0; nothing is accepted.
  - A reset asserted mid-stream discards the in-flight broadcast at that edge; the pointer restarts at 0.
- Arbitration is combinational each cycle:
  - Search ports rr_ptr, rr_ptr+1, ..., wrapping modulo N_PORT.
  - The first port with i_fu_valid=1 is the grant g; i_fu_ready[g]=1 and every other ready bit is 0.
  - If no port is valid, i_fu_ready is all 0.
- A handshake completes on port g when valid and ready are both 1. Non-granted ports keep valid high and hold tag/data stable; this is the producer's obligation, and the arbiter must not depend on it beyond the current cycle.
- i_fu_ready may depend combinationally on i_fu_valid. It must not depend on o_cdb_* next-state.
- The CDB cannot stall, so the output register is free every cycle. Throughput is one result per cycle whenever any port is valid.
- Registered update on a handshake:
  - o_cdb_valid<=1
  - o_cdb_tag<=tag[g]
  - o_cdb_wdata<=wdata[g]
  - o_cdb_src<=g
  - rr_ptr<=(g+1) mod N_PORT; at g=N_PORT-1 the pointer wraps to 0.
- Registered update with no handshake: o_cdb_valid<=0. Tag, data and src hold their previous values. rr_ptr holds.
- Latency: a result accepted in cycle t is broadcast with o_cdb_valid=1 during cycle t+1, exactly one cycle.
- Fairness: with all N_PORT ports continuously valid, grants rotate 0,1,...,N_PORT-1,0,...
  - A continuously valid port waits at most N_PORT-1 cycles.
- Single requester: a lone valid port is granted every cycle, whatever rr_ptr is.
- Data passes through unmodified. No arithmetic and no width conversion.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all i_fu_valid=1 -> i_fu_ready=0000 and o_cdb_valid=0 during reset. First cycle after release, ready=0001 (pointer 0).
- Single port: port 2 valid with tag=5, wdata=32'hDEADBEEF for 3 cycles -> ready=0100 each cycle. Next cycle each time: o_cdb_valid=1, tag=5, wdata=DEADBEEF, src=2.
- All valid, N_PORT=4, port p tag=p, data=100+p, held 8 cycles -> broadcast src sequence 0,1,2,3,0,1,2,3 with matching tag/data, one per cycle, no gaps.
- Pointer skip and wrap: rr_ptr=3, ports 1 and 3 valid -> port 3 granted, pointer becomes 0. Next cycle port 1 is granted.
- Idle gap: one handshake, then all valid=0 for 2 cycles -> o_cdb_valid pulses for exactly one cycle. tag, wdata and src hold their last values.
- Mid-stream reset: rst asserted in the cycle after a handshake -> o_cdb_valid=0 next cycle. Once rst releases with ports 1 and 2 valid, port 1 is granted first (pointer reset to 0).

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake and CDB broadcast bundle for cdb_arbiter.
// The producer side owns the valid/tag/data lines; the arbiter owns ready and
// the registered CDB outputs that reservation stations, RF and ROB snoop.
interface cdb_arbiter_if #(
  parameter int N_PORT            = 4,
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 4,
  parameter int BW_PORT           = $clog2(N_PORT)
);
  logic [N_PORT-1:0]                   i_fu_valid;
  logic [N_PORT-1:0]                   i_fu_ready;
  logic [N_PORT*BW_TAG-1:0]            i_fu_tag_flatten;
  logic [N_PORT*BW_PROCESSOR_DATA-1:0] i_fu_wdata_flatten;
  logic                                o_cdb_valid;
  logic [BW_TAG-1:0]                   o_cdb_tag;
  logic [BW_PROCESSOR_DATA-1:0]        o_cdb_wdata;
  logic [BW_PORT-1:0]                  o_cdb_src;

  // Functional units plus CDB snoopers
  modport master (
    output i_fu_valid, i_fu_tag_flatten, i_fu_wdata_flatten,
    input  i_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata, o_cdb_src
  );

  // The arbiter
  modport slave (
    input  i_fu_valid, i_fu_tag_flatten, i_fu_wdata_flatten,
    output i_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata, o_cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin pick of one functional-unit result per
// cycle, registered onto the CDB with one cycle of latency. The CDB never
// stalls, so the output register is free every cycle and ready is purely a
// function of valid, the rotating pointer and reset.
module cdb_arbiter #(
  parameter int N_PORT            = 4,
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 4,
  parameter int BW_PORT           = $clog2(N_PORT)
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  logic [BW_PORT-1:0]           rr_ptr_q, rr_ptr_d;
  logic                         cdb_valid_q, cdb_valid_d;
  logic [BW_TAG-1:0]            cdb_tag_q, cdb_tag_d;
  logic [BW_PROCESSOR_DATA-1:0] cdb_wdata_q, cdb_wdata_d;
  logic [BW_PORT-1:0]           cdb_src_q, cdb_src_d;

  logic                         grant_vld;
  logic [BW_PORT-1:0]           grant_idx;
  logic [BW_PORT-1:0]           cand;
  logic [N_PORT-1:0]            ready;
  logic                         handshake;

  // Search from rr_ptr upward with wrap; the first valid port wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_PORT; k++) begin
      cand = BW_PORT'((int'(rr_ptr_q) + k) % N_PORT);
      if (!grant_vld && bus.i_fu_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // One-hot ready on the grant; reset blocks all acceptance
  always_comb begin
    ready = '0;
    if (grant_vld && !rst) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign handshake = grant_vld && !rst;

  // Next-state for the broadcast register and pointer
  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_wdata_d = cdb_wdata_q;
    cdb_src_d   = cdb_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (handshake) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = bus.i_fu_tag_flatten[grant_idx*BW_TAG +: BW_TAG];
      cdb_wdata_d = bus.i_fu_wdata_flatten[grant_idx*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
      cdb_src_d   = grant_idx;
      rr_ptr_d    = (int'(grant_idx) == N_PORT - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // State register; a reset edge discards any in-flight broadcast
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_wdata_q <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_wdata_q <= cdb_wdata_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign bus.i_fu_ready  = ready;
  assign bus.o_cdb_valid = cdb_valid_q;
  assign bus.o_cdb_tag   = cdb_tag_q;
  assign bus.o_cdb_wdata = cdb_wdata_q;
  assign bus.o_cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; ready is checked 1 unit
// later, CDB outputs 1 unit after the following rising edge.
module tb_cdb_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  cdb_arbiter_if #(.N_PORT(NP), .BW_PROCESSOR_DATA(DW), .BW_TAG(TW), .BW_PORT(PW)) bus ();

  cdb_arbiter #(.N_PORT(NP), .BW_PROCESSOR_DATA(DW), .BW_TAG(TW), .BW_PORT(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic [NP-1:0] exp);
    #1;
    chk({tag, ".ready"}, 64'(bus.i_fu_ready), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [PW-1:0] src,
                         input logic [TW-1:0] t, input logic [DW-1:0] d);
    chk({tag, ".valid"}, 64'(bus.o_cdb_valid), 64'(v));
    chk({tag, ".src"},   64'(bus.o_cdb_src),   64'(src));
    chk({tag, ".tag"},   64'(bus.o_cdb_tag),   64'(t));
    chk({tag, ".wdata"}, 64'(bus.o_cdb_wdata), 64'(d));
  endtask

  task automatic set_port(input int p, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.i_fu_tag_flatten[p*TW +: TW]   = t;
    bus.i_fu_wdata_flatten[p*DW +: DW] = d;
  endtask

  initial begin
    int p;
    rst = 1'b1;
    bus.i_fu_valid = 4'b1111;
    for (int i = 0; i < NP; i++) set_port(i, TW'(i), DW'(100 + i));

    // Reset held 2 cycles with everything valid
    chk_ready("rst0", 4'b0000);
    tick();
    chk_ready("rst1", 4'b0000);
    chk("rst1.valid", 64'(bus.o_cdb_valid), 64'd0);
    tick();
    chk_cdb("rst2", 1'b0, 2'd0, 4'd0, 32'd0);
    rst = 1'b0;

    // All valid: grants rotate 0,1,2,3,0,1,2,3 with no gaps
    for (int i = 0; i < 8; i++) begin
      p = i % NP;
      chk_ready($sformatf("rr%0d", i), 4'(1 << p));
      tick();
      chk_cdb($sformatf("rr%0d", i), 1'b1, PW'(p), TW'(p), DW'(100 + p));
    end

    // Idle gap: one handshake on port 0 (pointer 0), then two empty cycles
    set_port(0, 4'd9, 32'h1234_5678);
    bus.i_fu_valid = 4'b0001;
    chk_ready("gap0", 4'b0001);
    tick();
    chk_cdb("gap0", 1'b1, 2'd0, 4'd9, 32'h1234_5678);
    bus.i_fu_valid = 4'b0000;
    chk_ready("gap1", 4'b0000);
    tick();
    chk_cdb("gap1", 1'b0, 2'd0, 4'd9, 32'h1234_5678);
    chk_ready("gap2", 4'b0000);
    tick();
    chk_cdb("gap2", 1'b0, 2'd0, 4'd9, 32'h1234_5678);

    // Lone requester on port 2, pointer at 1 then 3 then 3
    set_port(2, 4'd5, 32'hDEAD_BEEF);
    bus.i_fu_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      chk_ready($sformatf("single%0d", i), 4'b0100);
      tick();
      chk_cdb($sformatf("single%0d", i), 1'b1, 2'd2, 4'd5, 32'hDEAD_BEEF);
    end

    // Pointer 3 with ports 1 and 3 valid: 3 wins, pointer wraps, then 1
    bus.i_fu_valid = 4'b1010;
    chk_ready("wrap0", 4'b1000);
    tick();
    chk_cdb("wrap0", 1'b1, 2'd3, 4'd3, 32'd103);
    chk_ready("wrap1", 4'b0010);
    tick();
    chk_cdb("wrap1", 1'b1, 2'd1, 4'd1, 32'd101);

    // Pointer now 2; handshake on port 1 leaves pointer at 2, then reset
    bus.i_fu_valid = 4'b0010;
    chk_ready("mid0", 4'b0010);
    tick();
    chk_cdb("mid0", 1'b1, 2'd1, 4'd1, 32'd101);
    rst = 1'b1;
    bus.i_fu_valid = 4'b0110;
    chk_ready("mid1", 4'b0000);
    tick();
    chk_cdb("mid1", 1'b0, 2'd0, 4'd0, 32'd0);
    rst = 1'b0;
    chk_ready("mid2", 4'b0010);
    tick();
    chk_cdb("mid2", 1'b1, 2'd1, 4'd1, 32'd101);
    chk_ready("mid3", 4'b0100);
    tick();
    chk_cdb("mid3", 1'b1, 2'd2, 4'd5, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
